// File: rtl/bp_lce_mem_arb.sv
// Arbitrates a cache pipeline and an LCE onto one shared memory command port and routes read data back.
// Define BP_LCE_MEM_ARB_STARVE_EN to enable LCE starvation protection (counter, LCE_PRI state, busy_o).
module bp_lce_mem_arb #(
    parameter int pkt_width_p         = 64,
    parameter int data_width_p        = 512,
    parameter int timeout_max_limit_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    cache_v_i,
    input  logic [pkt_width_p-1:0]  cache_pkt_i,
    input  logic                    cache_rd_i,
    output logic                    cache_yumi_o,

    input  logic                    lce_v_i,
    input  logic [pkt_width_p-1:0]  lce_pkt_i,
    input  logic                    lce_rd_i,
    output logic                    lce_yumi_o,

    output logic                    mem_v_o,
    output logic [pkt_width_p-1:0]  mem_pkt_o,
    input  logic                    mem_ready_and_i,
    input  logic [data_width_p-1:0] mem_data_i,

    output logic                    cache_data_v_o,
    output logic                    lce_data_v_o,
    output logic [data_width_p-1:0] data_o,
    output logic                    busy_o
);

    if (timeout_max_limit_p < 1 || timeout_max_limit_p > 15) begin : g_bad_limit
        $error("bp_lce_mem_arb: timeout_max_limit_p must be in 1..15");
    end

    logic lce_pri;
    logic grant_cache;
    logic grant_lce;
    logic accepted_rd;
    logic rd_pending_r;
    logic owner_lce_r;

`ifdef BP_LCE_MEM_ARB_STARVE_EN
    localparam logic [3:0] limit_lp = 4'(timeout_max_limit_p);

    typedef enum logic {
        e_cache_pri,
        e_lce_pri
    } state_e;

    state_e      state_r, state_n;
    logic [3:0]  starve_cnt_r, starve_cnt_n;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        state_n      = state_r;

        // The counter keeps running while memory stalls; only the priority state is frozen.
        if (!lce_v_i || lce_yumi_o)
            starve_cnt_n = '0;
        else if (starve_cnt_r != limit_lp)
            starve_cnt_n = starve_cnt_r + 4'd1;

        if (mem_ready_and_i) begin
            unique case (state_r)
                e_cache_pri: if (lce_v_i && starve_cnt_n == limit_lp) state_n = e_lce_pri;
                e_lce_pri:   if (lce_yumi_o || !lce_v_i)              state_n = e_cache_pri;
                default:     state_n = e_cache_pri;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_cache_pri;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_n;
            starve_cnt_r <= starve_cnt_n;
        end
    end

    assign lce_pri = (state_r == e_lce_pri);
`else
    assign lce_pri = 1'b0;
`endif

    always_comb begin
        grant_lce    = lce_v_i & (lce_pri | ~cache_v_i);
        grant_cache  = cache_v_i & ~grant_lce;

        // Outputs are forced quiet while reset is held, independent of the registered state.
        cache_yumi_o = reset_n_i & grant_cache & mem_ready_and_i;
        lce_yumi_o   = reset_n_i & grant_lce & mem_ready_and_i;
        mem_v_o      = reset_n_i & (cache_v_i | lce_v_i);
        busy_o       = reset_n_i & lce_pri;
        mem_pkt_o    = '0;
        if (reset_n_i)
            mem_pkt_o = grant_lce ? lce_pkt_i : cache_pkt_i;

        accepted_rd  = (cache_yumi_o & cache_rd_i) | (lce_yumi_o & lce_rd_i);
    end

    // rd_pending is a one-cycle pulse per accepted read; owner only moves when a read is accepted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pending_r <= 1'b0;
            owner_lce_r  <= 1'b0;
        end else begin
            rd_pending_r <= accepted_rd;
            if (accepted_rd)
                owner_lce_r <= lce_yumi_o;
        end
    end

    assign cache_data_v_o = reset_n_i & rd_pending_r & ~owner_lce_r;
    assign lce_data_v_o   = reset_n_i & rd_pending_r &  owner_lce_r;
    assign data_o         = mem_data_i;

endmodule

// File: doc/bp_lce_mem_arb.md
BP_LCE_MEM_ARB -- requirements
Module: bp_lce_mem_arb

Interface
REQ-001 The block SHALL have parameter pkt_width_p, default 64, meaning width of a memory command packet.
REQ-002 The block SHALL have parameter data_width_p, default 512, meaning width of memory read data.
REQ-003 The block SHALL have parameter timeout_max_limit_p, default 4, meaning number of LCE-blocked cycles before LCE priority; legal range 1-15.
REQ-004 The block SHALL have ports: clk_i  in  1  clock; single clock, all state on rising edge.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 cache_v_i  in  1  cache pipeline request valid.
REQ-007 cache_pkt_i  in  pkt_width_p  cache request packet.
REQ-008 cache_rd_i  in  1  cache request returns read data.
REQ-009 cache_yumi_o  out  1  cache request accepted this cycle.
REQ-010 lce_v_i  in  1  LCE request valid; held until yumi.
REQ-011 lce_pkt_i  in  pkt_width_p  LCE request packet.
REQ-012 lce_rd_i  in  1  LCE request returns read data.
REQ-013 lce_yumi_o  out  1  LCE request accepted this cycle.
REQ-014 mem_v_o  out  1  packet valid to shared memory port.
REQ-015 mem_pkt_o  out  pkt_width_p  packet to memory.
REQ-016 mem_ready_and_i  in  1  memory accepts packet (ready&valid).
REQ-017 mem_data_i  in  data_width_p  memory read data, one cycle after accepted read.
REQ-018 cache_data_v_o / lce_data_v_o  out  1 each  read data valid for that requester.
REQ-019 data_o  out  data_width_p  mem_data_i passed through combinationally.
REQ-020 busy_o  out  1  tells cache to stop issuing; asserted in LCE-priority state.

Function
REQ-021 States SHALL be CACHE_PRI and LCE_PRI; reset state CACHE_PRI.
REQ-022 CACHE_PRI: grant cache if cache_v_i, else LCE if lce_v_i; mem_v_o = cache_v_i | lce_v_i; mem_pkt_o = granted packet.
REQ-023 LCE_PRI: grant LCE if lce_v_i, else cache; busy_o=1.
REQ-024 Handshake: a yumi SHALL assert only for the granted requester and only when mem_ready_and_i=1; never both yumis in one cycle.
REQ-025 Starvation counter (4 bits): increments each cycle lce_v_i=1 and lce_yumi_o=0; clears when lce_v_i=0 or lce_yumi_o=1; saturates at timeout_max_limit_p.
REQ-026 CACHE_PRI -> LCE_PRI when counter == timeout_max_limit_p at clock edge and lce_v_i=1.
REQ-027 LCE_PRI -> CACHE_PRI on lce_yumi_o=1, or when lce_v_i=0; counter cleared on transition.
REQ-028 Read return: on an accepted read, owner and rd_pending registers SHALL set; next cycle exactly one of cache_data_v_o/lce_data_v_o asserts; writes produce no data valid.
REQ-029 Back-to-back accepted reads SHALL each yield data valid the following cycle with correct owner.
REQ-030 mem_ready_and_i=0 SHALL hold all state except the starvation counter, which still counts.
REQ-031 Latency: packet to mem_pkt_o combinational, zero cycles; read data valid exactly one cycle after acceptance.

Reset
REQ-032 On reset_n_i=0, asynchronously: state=CACHE_PRI, counter=0, rd_pending=0, owner=cache.
REQ-033 During reset all outputs SHALL be 0 except data_o (pass-through); yumis, mem_v_o, busy_o, data valids forced 0.
REQ-034 Reset asserted mid-read SHALL drop the pending data valid; no data valid after release until a new accepted read.

Configuration
REQ-035 Macro BP_LCE_MEM_ARB_STARVE_EN defined: starvation counter, LCE_PRI state and busy_o behave per REQ-023..027.
REQ-036 Macro undefined: strict cache priority, no counter or LCE_PRI state, busy_o tied 0; all other behaviour identical.

Verification
REQ-037 Reset with both valids high -> all yumis/mem_v_o/busy_o 0; release -> cache_yumi_o=1 first cycle.
REQ-038 cache_v_i and lce_v_i held 1, ready=1, limit=4 -> 4 cache grants, busy_o=1 cycle 5, lce_yumi_o=1 cycle 5, cache regains cycle 6.
REQ-039 Macro undefined, same stimulus 20 cycles -> lce_yumi_o never 1, busy_o 0.
REQ-040 Alternating cache read, LCE read, cache write with ready=1 -> cache_data_v_o, lce_data_v_o, then none, each one cycle later, data_o = mem_data_i.
REQ-041 ready=0 for 3 cycles with lce_v_i=1 only -> no yumi, mem_v_o=1, pkt stable; ready=1 -> lce_yumi_o=1.
REQ-042 reset_n_i pulsed low the cycle after an accepted read -> no data valid asserts, state CACHE_PRI, counter 0.
